counter: RTL and testbench
==========================

Name: counter

Overview:
Modulo-(MAX+1) up/down digit counter used as one digit stage of the chess-clock time chain. Steps up on IMPULSE and down on DECREMENT_IMPULSE when enabled. Produces a combinational OVERFLOW (carry/borrow) so digits cascade: one stage's OVERFLOW drives the next stage's IMPULSE or DECREMENT_IMPULSE. MAX is a runtime input, so one module serves modulo-10, modulo-6, etc.

Parameters:
WIDTH, 4, bit width of MAX and COUNT.

Ports:
CLK  input  1  system clock; all state changes on its rising edge
CLR  input  1  synchronous active-high reset: COUNT<=0
CE  input  1  clock enable; when 0, COUNT holds and OVERFLOW=0
IMPULSE  input  1  count-up request, sampled each enabled cycle (level, one step per cycle while high)
DECREMENT_IMPULSE  input  1  count-down request, same sampling rules
MAX  input  WIDTH  terminal value; counting range 0..MAX inclusive
COUNT  output  WIDTH  current registered count
OVERFLOW  output  1  combinational carry/borrow flag for cascading

Behaviour:
- One clock (CLK); reset CLR is synchronous and active-high. Reset value: COUNT=0. OVERFLOW is combinational and is therefore 0 during any cycle with CLR=1.
- Priority per rising edge: CLR > CE=0 (hold) > step.
- Define up = IMPULSE & ~DECREMENT_IMPULSE; down = DECREMENT_IMPULSE & ~IMPULSE. Both high or both low: no step, COUNT holds.
- Up step: if COUNT >= MAX then COUNT<=0, else COUNT<=COUNT+1.
- Down step: if COUNT == 0 then COUNT<=MAX; else if COUNT > MAX then COUNT<=MAX; else COUNT<=COUNT-1.
- OVERFLOW = ~CLR & CE & ((up & COUNT>=MAX) | (down & COUNT==0)). It is high in the same cycle as the wrapping edge and is purely combinational, with no register, so cascaded stages step on that same edge.
- Latency: one clock from request to COUNT update; zero cycles for OVERFLOW.
- IMPULSE held high steps once per clock. With MAX=5 the sequence is 0,1,2,3,4,5,0,… and OVERFLOW is high during each cycle where COUNT=5.
- MAX=0: COUNT stays 0. OVERFLOW is high on every enabled up or down step.
- MAX changed at runtime below the current COUNT: the next up step wraps to 0 with OVERFLOW. The next down step loads MAX with no OVERFLOW.
- CLR during counting: COUNT=0 on the next edge regardless of IMPULSE, DECREMENT_IMPULSE or CE.
- All arithmetic is unsigned at WIDTH bits. The design never relies on natural binary wrap.
- X on an unused request input is not a supported state. Integrators tie unused requests to 0.

Test Plan:
1. CLR=1, CE=1, MAX=5, IMPULSE=0 for one edge, then CLR=0 -> COUNT=0, OVERFLOW=0.
2. IMPULSE=1 held for 7 clocks, MAX=5 -> COUNT 1,2,3,4,5,0,1. OVERFLOW=1 only in the cycle where COUNT=5 and IMPULSE=1.
3. COUNT=0, DECREMENT_IMPULSE=1 for 3 clocks, MAX=5 -> COUNT 5,4,3. OVERFLOW=1 only in the cycle where COUNT=0.
4. CE=0 with IMPULSE=1 for 3 clocks at COUNT=3 -> COUNT stays 3, OVERFLOW=0. Then IMPULSE=DECREMENT_IMPULSE=1 with CE=1 -> COUNT stays 3.
5. COUNT=4, CLR=1 with IMPULSE=1 for one edge -> COUNT=0, OVERFLOW=0. CLR=0 -> counting resumes 1,2,…
6. COUNT=8 with MAX=9, then MAX changed to 5 and one IMPULSE -> COUNT=0, OVERFLOW=1. Separately, MAX=0 with IMPULSE=1 -> COUNT stays 0 and OVERFLOW=1 every cycle.

Source files
------------

// File: rtl/counter.sv
// One digit stage of the chess-clock time chain: a modulo-(MAX+1) up/down counter
// with a combinational carry/borrow so that neighbouring digits step on the same edge.
module counter #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             CE,
  input  logic             IMPULSE,
  input  logic             DECREMENT_IMPULSE,
  input  logic [WIDTH-1:0] MAX,
  output logic [WIDTH-1:0] COUNT,
  output logic             OVERFLOW
);

  logic             step_up;
  logic             step_down;
  logic             at_top;
  logic             at_zero;
  logic [WIDTH-1:0] next_count;

  assign step_up   = IMPULSE & ~DECREMENT_IMPULSE;
  assign step_down = DECREMENT_IMPULSE & ~IMPULSE;
  assign at_top    = (COUNT >= MAX);
  assign at_zero   = (COUNT == '0);

  // A count left above a freshly lowered MAX is treated as "at the top" for up steps
  // and is clamped to MAX on down steps, so no stage ever relies on binary wrap.
  always_comb begin
    next_count = COUNT;
    if (step_up) begin
      if (at_top) next_count = '0;
      else        next_count = COUNT + WIDTH'(1);
    end else if (step_down) begin
      if (at_zero)          next_count = MAX;
      else if (COUNT > MAX) next_count = MAX;
      else                  next_count = COUNT - WIDTH'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR)     COUNT <= '0;
    else if (CE) COUNT <= next_count;
  end

  assign OVERFLOW = ~CLR & CE & ((step_up & at_top) | (step_down & at_zero));

endmodule

// File: tb/tb_counter.sv
// Scoreboard bench for counter: directed test-plan sequences followed by random
// traffic, checked against an arithmetic model of the counting rules.
module tb_counter;

  localparam int WIDTH = 4;

  typedef struct {
    logic [WIDTH-1:0] count;
    logic             ovf;
    bit               chkCount;
  } expT;

  logic             CLK = 1'b0;
  logic             CLR = 1'b0;
  logic             CE = 1'b0;
  logic             IMPULSE = 1'b0;
  logic             DECREMENT_IMPULSE = 1'b0;
  logic [WIDTH-1:0] MAX = '0;
  logic [WIDTH-1:0] COUNT;
  logic             OVERFLOW;

  expT expQ[$];
  int  compared = 0;
  int  mismatched = 0;
  int  modelCount = 0;
  bit  modelKnown = 1'b0;
  bit  stimDone = 1'b0;

  counter #(.WIDTH(WIDTH)) dut (
    .CLK(CLK),
    .CLR(CLR),
    .CE(CE),
    .IMPULSE(IMPULSE),
    .DECREMENT_IMPULSE(DECREMENT_IMPULSE),
    .MAX(MAX),
    .COUNT(COUNT),
    .OVERFLOW(OVERFLOW)
  );

  always #5 CLK = ~CLK;

  // Drive one cycle of inputs, push the expected outputs for that cycle, then
  // advance the model across the rising edge.
  task automatic applyStimulus(input bit clr, input bit ce, input bit inc,
                               input bit dec, input int maxv);
    expT e;
    bit  up, down;
    int  nxt;
    CLR = clr; CE = ce; IMPULSE = inc; DECREMENT_IMPULSE = dec;
    MAX = WIDTH'(maxv);
    up   = inc && !dec;
    down = dec && !inc;
    e.count    = WIDTH'(modelCount);
    e.chkCount = modelKnown;
    e.ovf      = !clr && ce && ((up && modelCount >= maxv) || (down && modelCount == 0));
    expQ.push_back(e);
    if (clr)       nxt = 0;
    else if (!ce)  nxt = modelCount;
    else if (up)   nxt = (modelCount >= maxv) ? 0 : modelCount + 1;
    else if (down) nxt = (modelCount == 0) ? maxv : ((modelCount > maxv) ? maxv : modelCount - 1);
    else           nxt = modelCount;
    @(posedge CLK);
    #1;
    if (clr) modelKnown = 1'b1;
    modelCount = nxt;
  endtask

  task automatic checkOutput(input expT e);
    if (e.chkCount) begin
      compared++;
      if (COUNT !== e.count) begin
        mismatched++;
        $display("[TB] FAIL count at %0t: got %0d expected %0d", $time, COUNT, e.count);
      end
    end
    compared++;
    if (OVERFLOW !== e.ovf) begin
      mismatched++;
      $display("[TB] FAIL overflow at %0t: got %0b expected %0b (count %0d)",
               $time, OVERFLOW, e.ovf, COUNT);
    end
  endtask

  // Monitor: the DUT presents an output every cycle; sample it mid-cycle.
  always @(negedge CLK) begin
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  initial begin
    @(posedge CLK);
    #1;
    // Reset, then count up through a MAX=5 wrap
    applyStimulus(1, 1, 0, 0, 5);
    applyStimulus(0, 1, 0, 0, 5);
    for (int i = 0; i < 7; i++) applyStimulus(0, 1, 1, 0, 5);
    // Back to 0, then count down through a borrow
    applyStimulus(1, 1, 0, 0, 5);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 1, 5);
    // Hold with CE low, then both requests high
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 5);
    applyStimulus(0, 1, 1, 1, 5);
    // Clear in the middle of counting
    applyStimulus(0, 1, 1, 0, 5);
    applyStimulus(1, 1, 1, 0, 5);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 0, 5);
    // Lower MAX below the count, then MAX=0
    applyStimulus(1, 1, 0, 0, 9);
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, 1, 0, 9);
    applyStimulus(0, 1, 1, 0, 5);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 0, 0);
    for (int i = 0; i < 2; i++) applyStimulus(0, 1, 0, 1, 0);
    // Count above a lowered MAX on a down step
    for (int i = 0; i < 12; i++) applyStimulus(0, 1, 1, 0, 15);
    applyStimulus(0, 1, 0, 1, 7);
    // Random traffic
    begin
      int maxv = 9;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 15) == 0) maxv = $urandom_range(0, 15);
        applyStimulus($urandom_range(0, 31) == 0, $urandom_range(0, 7) != 0,
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), maxv);
      end
    end
    CE = 1'b0; IMPULSE = 1'b0; DECREMENT_IMPULSE = 1'b0;
    stimDone = 1'b1;
  end

  initial begin
    fork
      wait (stimDone);
      #100000;
    join_any
    disable fork;
    repeat (3) @(posedge CLK);
    compared++;
    if (!stimDone || expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL drain: done=%0b pending=%0d expected done=1 pending=0",
               stimDone, expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
